// File: rtl/idli_pc_seq_m.sv
// idli_pc_seq_m: bit-serial program counter for the idli core.
// The PC lives in a rotating register. One SLICE_WIDTH-bit slice is updated
// per enabled clock, starting with the LSB slice. A full update takes
// N = PC_WIDTH/SLICE_WIDTH enabled cycles.
// Operations: increment, absolute load, PC-relative add, and hold.
// The unit owns its slice counter and exports first/last-slice strobes.
// Optional feature (macro IDLI_PC_LINK_EN): a link register that tracks
// old PC + INC, presented slice-aligned with o_pc_q for return addresses.
// Handshake: there is no valid/ready pair. i_pc_en is a pure advance
// qualifier. Each cycle with i_pc_en high consumes one i_pc_data slice and
// retires one o_pc_q slice. With i_pc_en low, every flop holds.
module idli_pc_seq_m #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         SLICE_WIDTH = 4,
  parameter int unsigned         INC         = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_pc_gck,
  input  logic                   i_pc_rst_n,
  input  logic                   i_pc_en,
  input  logic [1:0]             i_pc_op,
  input  logic [SLICE_WIDTH-1:0] i_pc_data,
  output logic [SLICE_WIDTH-1:0] o_pc_q,
  output logic                   o_pc_first,
  output logic                   o_pc_last,
  output logic [SLICE_WIDTH-1:0] o_pc_link_q
);

  localparam int unsigned             N         = PC_WIDTH / SLICE_WIDTH;
  localparam int unsigned             CTR_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CTR_W-1:0]        LAST_CTR  = CTR_W'(N - 1);
  localparam logic [SLICE_WIDTH-1:0]  INC_SLICE = SLICE_WIDTH'(INC);

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_LOAD = 2'd1,
    OP_REL  = 2'd2,
    OP_HOLD = 2'd3
  } op_e;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;
  op_e                    op_q, op_d, cur_op;
  logic                   carry_q, carry_d;
  logic                   first, cin;
  logic [SLICE_WIDTH-1:0] s, inc_add, new_slice;
  logic [SLICE_WIDTH:0]   sum_inc, sum_rel;
  logic                   co;

  assign first      = (ctr_q == '0);
  assign s          = pc_q[SLICE_WIDTH-1:0];
  assign o_pc_q     = s;
  assign o_pc_first = first;
  assign o_pc_last  = (ctr_q == LAST_CTR);

  // Slice datapath and next-state logic; everything holds unless enabled.
  always_comb begin
    pc_d      = pc_q;
    ctr_d     = ctr_q;
    op_d      = op_q;
    carry_d   = carry_q;
    cur_op    = first ? op_e'(i_pc_op) : op_q;
    cin       = first ? 1'b0 : carry_q;
    inc_add   = first ? INC_SLICE : '0;
    sum_inc   = {1'b0, s} + {1'b0, inc_add} + {{SLICE_WIDTH{1'b0}}, cin};
    sum_rel   = {1'b0, s} + {1'b0, i_pc_data} + {{SLICE_WIDTH{1'b0}}, cin};
    new_slice = s;
    co        = 1'b0;
    case (cur_op)
      OP_INC:  {co, new_slice} = sum_inc;
      OP_LOAD: new_slice = i_pc_data;
      OP_REL:  {co, new_slice} = sum_rel;
      default: new_slice = s;
    endcase
    if (i_pc_en) begin
      // Rotate right: the freshly computed slice enters at the MSB end.
      pc_d = pc_q >> SLICE_WIDTH;
      pc_d[PC_WIDTH-1 -: SLICE_WIDTH] = new_slice;
      ctr_d   = (ctr_q == LAST_CTR) ? '0 : ctr_q + 1'b1;
      carry_d = co;
      if (first) op_d = cur_op;
    end
  end

  // Main PC state; reset abandons any partially rotated update.
  always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
    if (!i_pc_rst_n) begin
      pc_q    <= RESET_PC;
      ctr_q   <= '0;
      op_q    <= OP_HOLD;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ctr_q   <= ctr_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

`ifdef IDLI_PC_LINK_EN
  logic [PC_WIDTH-1:0]  link_q, link_d;
  logic                 link_c_q, link_c_d;
  logic [SLICE_WIDTH:0] link_sum;

  // Link register builds (new PC + INC) from the new slices. It then lines
  // up with the matching o_pc_q slice as the pre-update PC + INC.
  always_comb begin
    link_d   = link_q;
    link_c_d = link_c_q;
    link_sum = {1'b0, new_slice} + {1'b0, inc_add} +
               {{SLICE_WIDTH{1'b0}}, (first ? 1'b0 : link_c_q)};
    if (i_pc_en) begin
      link_d = link_q >> SLICE_WIDTH;
      link_d[PC_WIDTH-1 -: SLICE_WIDTH] = link_sum[SLICE_WIDTH-1:0];
      link_c_d = link_sum[SLICE_WIDTH];
    end
  end

  // Link state flops.
  always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
    if (!i_pc_rst_n) begin
      link_q   <= RESET_PC + PC_WIDTH'(INC);
      link_c_q <= 1'b0;
    end else begin
      link_q   <= link_d;
      link_c_q <= link_c_d;
    end
  end

  assign o_pc_link_q = link_q[SLICE_WIDTH-1:0];
`else
  assign o_pc_link_q = '0;
`endif

endmodule

// File: tb/tb_idli_pc_seq_m.sv
// Testbench for idli_pc_seq_m.
// The reference model works on whole PC words. Per-slice expected outputs
// are queued by the driver and consumed by a negedge monitor.
module tb_idli_pc_seq_m #(
  parameter int SW = 4
);
  localparam int             PW       = 16;
  localparam int             N        = PW / SW;
  localparam int             INC      = 2;
  localparam logic [PW-1:0]  RESET_PC = 16'h0000;
  localparam int             EW       = 2 * SW + 2;

  logic          gck   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic [1:0]    op    = 2'd3;
  logic [SW-1:0] data  = '0;
  logic [SW-1:0] o_pc_q, o_pc_link_q;
  logic          o_pc_first, o_pc_last;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [PW-1:0] pc_model;
  int            errors = 0;
  int            checks = 0;

  idli_pc_seq_m #(
    .PC_WIDTH(PW), .SLICE_WIDTH(SW), .INC(INC), .RESET_PC(RESET_PC)
  ) dut (
    .i_pc_gck    (gck),
    .i_pc_rst_n  (rst_n),
    .i_pc_en     (en),
    .i_pc_op     (op),
    .i_pc_data   (data),
    .o_pc_q      (o_pc_q),
    .o_pc_first  (o_pc_first),
    .o_pc_last   (o_pc_last),
    .o_pc_link_q (o_pc_link_q)
  );

  // Clock
  always #5 gck = ~gck;

  function automatic logic [SW-1:0] slice_of(input logic [PW-1:0] w, input int k);
    logic [PW-1:0] t;
    t = w >> (k * SW);
    return t[SW-1:0];
  endfunction

  function automatic logic [SW-1:0] link_of(input logic [PW-1:0] p, input int k);
`ifdef IDLI_PC_LINK_EN
    return slice_of(p + PW'(INC), k);
`else
    return '0;
`endif
  endfunction

  function automatic logic [EW-1:0] exp_entry(input logic [PW-1:0] p, input int k);
    return {slice_of(p, k), 1'(k == 0), 1'(k == N - 1), link_of(p, k)};
  endfunction

  function automatic logic [PW-1:0] next_pc(input logic [1:0] o, input logic [PW-1:0] p,
                                            input logic [PW-1:0] d);
    case (o)
      2'd0:    return p + PW'(INC);
      2'd1:    return d;
      2'd2:    return p + d;
      default: return p;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_pc_q", 16'(o_pc_q), 16'(slice_of(RESET_PC, 0)));
    check("rst_first", 16'(o_pc_first), 16'd1);
    check("rst_last", 16'(o_pc_last), 16'(N == 1));
    check("rst_link", 16'(o_pc_link_q), 16'(link_of(RESET_PC, 0)));
  endtask

  // One driven cycle: inputs applied after the edge, expected slice queued.
  task automatic drive(input logic e, input logic [1:0] o, input logic [SW-1:0] d,
                       input logic [PW-1:0] p, input int k);
    @(posedge gck);
    #2;
    en   = e;
    op   = o;
    data = d;
    exp_q.push_back(exp_entry(p, k));
  endtask

  // Full N-slice operation; optional stall of stall_len cycles before slice stall_at.
  task automatic run_op(input logic [1:0] o, input logic [PW-1:0] d,
                        input int stall_at, input int stall_len);
    logic [PW-1:0] p;
    p = pc_model;
    for (int k = 0; k < N; k++) begin
      if (k == stall_at)
        for (int j = 0; j < stall_len; j++)
          drive(1'b0, 2'($urandom_range(0, 3)), SW'($urandom), p, k);
      drive(1'b1, (k == 0) ? o : 2'($urandom_range(0, 3)), slice_of(d, k), p, k);
    end
    pc_model = next_pc(o, p, d);
  endtask

  // Start an operation and assert reset while the counter sits on abort_at.
  task automatic run_abort(input logic [1:0] o, input logic [PW-1:0] d, input int abort_at);
    logic [PW-1:0] p;
    p = pc_model;
    for (int k = 0; k <= abort_at; k++)
      drive(1'b1, (k == 0) ? o : 2'($urandom_range(0, 3)), slice_of(d, k), p, k);
    @(negedge gck);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_reset_outputs();
    pc_model = RESET_PC;
    @(posedge gck);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare presented outputs against the oldest expectation.
  always @(negedge gck) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc_q", 16'(o_pc_q), 16'(mon_e[EW-1 -: SW]));
      check("first", 16'(o_pc_first), 16'(mon_e[SW+1]));
      check("last", 16'(o_pc_last), 16'(mon_e[SW]));
      check("link", 16'(o_pc_link_q), 16'(mon_e[SW-1:0]));
    end
  end

  // Watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stimulus
  initial begin
    int sa;
    sa = (N > 2) ? 2 : 1;
    repeat (2) @(posedge gck);
    #1;
    check_reset_outputs();
    pc_model = RESET_PC;
    @(negedge gck);
    rst_n = 1'b1;

    // Increments from reset
    run_op(2'd0, '0, -1, 0);
    run_op(2'd0, '0, -1, 0);
    run_op(2'd0, '0, -1, 0);
    // Carry ripple and wrap, no sticky carry afterwards
    run_op(2'd1, 16'h00FE, -1, 0);
    run_op(2'd0, '0, -1, 0);
    run_op(2'd1, 16'hFFFE, -1, 0);
    run_op(2'd0, '0, -1, 0);
    run_op(2'd0, '0, -1, 0);
    // Load and relative
    run_op(2'd1, 16'hA5C3, -1, 0);
    run_op(2'd3, 16'hFFFF, -1, 0);
    run_op(2'd1, 16'h1000, -1, 0);
    run_op(2'd2, 16'hFFF0, -1, 0);
    run_op(2'd3, '0, -1, 0);
    // Stalls mid-window and on slice 0
    run_op(2'd1, 16'h0FFE, -1, 0);
    run_op(2'd0, '0, sa, 3);
    run_op(2'd0, '0, 0, 2);
    run_op(2'd3, '0, -1, 0);
    // Reset mid-REL
    run_op(2'd1, 16'h3000, -1, 0);
    run_abort(2'd2, 16'h0010, sa);
    run_op(2'd0, '0, -1, 0);
    // Link during a load
    run_op(2'd1, 16'h1234, -1, 0);
    run_op(2'd1, 16'h4000, -1, 0);
    run_op(2'd3, '0, -1, 0);
    // Random ops and stalls
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
             int'($urandom_range(1, 3)));
    end
    // Observe the last result
    drive(1'b0, 2'd3, '0, pc_model, 0);
    @(negedge gck);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
